// File: rtl/pipe_pkg.sv
// Shared constants and width helpers for the elastic pipeline stage buffer.
package pipe_pkg;

  localparam int PIPE_W     = 200;
  localparam int PIPE_DEPTH = 2;

  // Pointer width: enough bits to index DEPTH entries, never less than one.
  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width: must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between the upstream stage, the buffer and the downstream stage.
interface pipe_stage_buf_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W,
  parameter int DEPTH = PIPE_DEPTH
);

  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [cnt_w(DEPTH)-1:0]   count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/pipe_buf_ptr.sv
// Circular buffer pointer: wraps from DEPTH-1 to 0, clear beats increment.
module pipe_buf_ptr
  import pipe_pkg::*;
#(
  parameter  int DEPTH = PIPE_DEPTH,
  localparam int PW    = idx_w(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the simulator evaluates blocks.
  always_ff @(posedge Clk) begin
    if (!Rst_n || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic first-word-fall-through pipeline buffer with synchronous flush.
// Every output is decoded from registered state only; in_ready does not see out_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W,
  parameter int DEPTH = PIPE_DEPTH
) (
  input logic              Clk,
  input logic              Rst_n,
  pipe_stage_buf_if.slave  bus
);

  localparam int PW = idx_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A flush in the same cycle discards both the incoming word and the retirement.
  assign do_wr = bus.in_valid  && bus.in_ready  && !bus.flush;
  assign do_rd = bus.out_valid && bus.out_ready && !bus.flush;

  pipe_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (bus.flush),
    .inc   (do_wr),
    .ptr   (wr_ptr)
  );

  pipe_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (bus.flush),
    .inc   (do_rd),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      count_q <= '0;
    end else if (bus.flush) begin
      count_q <= '0;
    end else if (do_wr && !do_rd) begin
      count_q <= count_q + CW'(1);
    end else if (do_rd && !do_wr) begin
      count_q <= count_q - CW'(1);
    end
  end

  // NOTE: storage has no reset; occupancy gates visibility, so stale contents
  // are never observed and the array maps onto plain registers or RAM.
  always_ff @(posedge Clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  assign bus.in_ready  = !full && Rst_n;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: queue models for DEPTH=2 and DEPTH=3 buffers, checked every cycle.
module tb_pipe_stage_buf;

  localparam int W = 200;
  typedef logic [W-1:0] word_t;

  logic Clk;
  logic Rst_n;

  pipe_stage_buf_if #(.WIDTH(W), .DEPTH(2)) ifa ();
  pipe_stage_buf_if #(.WIDTH(W), .DEPTH(3)) ifb ();

  pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) u_a (.Clk(Clk), .Rst_n(Rst_n), .bus(ifa.slave));
  pipe_stage_buf #(.WIDTH(W), .DEPTH(3)) u_b (.Clk(Clk), .Rst_n(Rst_n), .bus(ifb.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each buffer is a bounded FIFO queue.
  word_t qa[$];
  word_t qb[$];
  bit    started = 0;
  bit    pa, ra, pb, rb;

  always @(posedge Clk) begin
    started <= 1'b1;
    if (!Rst_n || ifa.flush) begin
      qa.delete();
    end else begin
      pa = ifa.in_valid && (qa.size() < 2);
      ra = ifa.out_ready && (qa.size() > 0);
      if (ra) void'(qa.pop_front());
      if (pa) qa.push_back(ifa.in_data);
    end
    if (!Rst_n || ifb.flush) begin
      qb.delete();
    end else begin
      pb = ifb.in_valid && (qb.size() < 3);
      rb = ifb.out_ready && (qb.size() > 0);
      if (rb) void'(qb.pop_front());
      if (pb) qb.push_back(ifb.in_data);
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  bit    a_hold = 0, b_hold = 0;
  word_t a_prev, b_prev;

  always @(negedge Clk) begin
    if (started) begin
      check("a_in_ready",  256'(ifa.in_ready),  256'(Rst_n && qa.size() < 2));
      check("a_out_valid", 256'(ifa.out_valid), 256'(qa.size() > 0));
      check("a_out_data",  256'(ifa.out_data),  256'(qa.size() > 0 ? qa[0] : word_t'(0)));
      check("a_count",     256'(ifa.count),     256'(qa.size()));
      check("b_in_ready",  256'(ifb.in_ready),  256'(Rst_n && qb.size() < 3));
      check("b_out_valid", 256'(ifb.out_valid), 256'(qb.size() > 0));
      check("b_out_data",  256'(ifb.out_data),  256'(qb.size() > 0 ? qb[0] : word_t'(0)));
      check("b_count",     256'(ifb.count),     256'(qb.size()));
      if (a_hold) check("a_hold_stable", 256'(ifa.out_data), 256'(a_prev));
      if (b_hold) check("b_hold_stable", 256'(ifb.out_data), 256'(b_prev));
      a_hold = Rst_n && ifa.out_valid && !ifa.out_ready && !ifa.flush;
      b_hold = Rst_n && ifb.out_valid && !ifb.out_ready && !ifb.flush;
      a_prev = ifa.out_data;
      b_prev = ifb.out_data;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic word_t rnd_word();
    word_t w = '0;
    for (int k = 0; k < 7; k++) w = (w << 32) | word_t'($urandom);
    return w;
  endfunction

  // DEPTH=3 pattern table: {in_valid, out_ready} per cycle.
  logic [1:0] pat [0:13] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01,
                             2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01};

  initial begin
    Rst_n = 1'b0;
    ifa.flush = 0; ifa.in_valid = 1; ifa.in_data = W'(1); ifa.out_ready = 0;
    ifb.flush = 0; ifb.in_valid = 1; ifb.in_data = W'(1); ifb.out_ready = 0;

    // Reset held three cycles with in_valid asserted.
    repeat (3) begin
      tick();
      check("rst_in_ready",  256'(ifa.in_ready),  256'(0));
      check("rst_out_valid", 256'(ifa.out_valid), 256'(0));
      check("rst_out_data",  256'(ifa.out_data),  256'(0));
      check("rst_count",     256'(ifa.count),     256'(0));
    end
    Rst_n = 1'b1;
    ifa.in_valid = 0;
    ifb.in_valid = 0;
    tick();
    check("rel_in_ready", 256'(ifa.in_ready), 256'(1));
    check("rel_count",    256'(ifa.count),    256'(0));

    // Fill / drain DEPTH=2.
    ifa.in_valid = 1; ifa.in_data = W'('hA);
    tick();
    check("fill1_data", 256'(ifa.out_data), 256'('hA));
    ifa.in_data = W'('hB);
    tick();
    check("fill2_count", 256'(ifa.count),    256'(2));
    check("fill2_ready", 256'(ifa.in_ready), 256'(0));
    ifa.in_data = W'('hD);
    tick();
    check("fill3_count", 256'(ifa.count),    256'(2));
    ifa.in_valid = 0; ifa.out_ready = 1;
    check("drain_a", 256'(ifa.out_data), 256'('hA));
    tick();
    check("drain_b", 256'(ifa.out_data), 256'('hB));
    check("drain_b_count", 256'(ifa.count), 256'(1));
    tick();
    check("drain_empty_valid", 256'(ifa.out_valid), 256'(0));
    check("drain_empty_data",  256'(ifa.out_data),  256'(0));
    ifa.out_ready = 0;

    // Streaming: one word in and one out per cycle, occupancy 1.
    ifa.in_valid = 1; ifa.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      ifa.in_data = W'(i + 'h40);
      tick();
      check("stream_data",  256'(ifa.out_data), 256'(i + 'h40));
      check("stream_count", 256'(ifa.count),    256'(1));
    end
    ifa.in_valid = 0;
    tick();
    check("stream_drained", 256'(ifa.count), 256'(0));
    ifa.out_ready = 0;

    // Flush while full, with push and pop requested.
    ifa.in_valid = 1; ifa.in_data = W'('h1);
    tick();
    ifa.in_data = W'('h2);
    tick();
    check("pre_flush_count", 256'(ifa.count), 256'(2));
    ifa.flush = 1; ifa.in_data = W'('hC); ifa.out_ready = 1;
    tick();
    check("flush_count", 256'(ifa.count),     256'(0));
    check("flush_valid", 256'(ifa.out_valid), 256'(0));
    ifa.flush = 0; ifa.in_valid = 0;
    tick();
    check("post_flush_valid", 256'(ifa.out_valid), 256'(0));

    // Flush at occupancy 1 where push and pop would both otherwise fire.
    ifa.in_valid = 1; ifa.in_data = W'('h5); ifa.out_ready = 0;
    tick();
    ifa.flush = 1; ifa.in_data = W'('hC); ifa.out_ready = 1;
    tick();
    check("flush2_count", 256'(ifa.count), 256'(0));
    ifa.flush = 0; ifa.in_valid = 0;
    tick();
    check("flush2_no_c", 256'(ifa.out_data), 256'(0));
    ifa.out_ready = 0;

    // DEPTH=3 wrap patterns, including full with out_ready high.
    for (int k = 0; k < 14; k++) begin
      ifb.in_valid  = pat[k][1];
      ifb.out_ready = pat[k][0];
      ifb.in_data   = W'('h100 + k);
      tick();
      if (k == 2) begin
        check("b_full_count", 256'(ifb.count),    256'(3));
        check("b_full_ready", 256'(ifb.in_ready), 256'(0));
        check("b_full_head",  256'(ifb.out_data), 256'('h100));
      end
      if (k == 3) check("b_full_pop_count", 256'(ifb.count), 256'(2));
    end
    ifb.in_valid = 0; ifb.out_ready = 1;
    repeat (4) tick();
    ifb.out_ready = 0;

    // Random traffic, backpressure and occasional flush on both buffers.
    for (int c = 0; c < 10000; c++) begin
      ifa.in_valid  = ($urandom_range(0, 3) != 0);
      ifa.in_data   = rnd_word();
      ifa.out_ready = ($urandom_range(0, 2) != 0);
      ifa.flush     = ($urandom_range(0, 99) == 0);
      ifb.in_valid  = ($urandom_range(0, 1) != 0);
      ifb.in_data   = rnd_word();
      ifb.out_ready = ($urandom_range(0, 3) == 0);
      ifb.flush     = ($urandom_range(0, 99) == 0);
      tick();
    end
    ifa.in_valid = 0; ifa.flush = 0; ifa.out_ready = 1;
    ifb.in_valid = 0; ifb.flush = 0; ifb.out_ready = 1;
    repeat (4) tick();
    check("end_a_empty", 256'(ifa.count), 256'(0));
    check("end_b_empty", 256'(ifb.count), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
